// File: rtl/b10_vote_tx.sv
// Vote-code frame transmitter with acknowledge timeout, bounded retries and a sticky error flag.
// Optional feature: define B10_VOTE_TX_PARITY_EN to append an even-parity bit to each frame.
module b10_vote_tx #(
    parameter int TIMEOUT   = 15,
    parameter int MAX_RETRY = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic [3:0] vote,
    input  logic       rx_ack,
    output logic       tx_req,
    output logic       tx_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

`ifdef B10_VOTE_TX_PARITY_EN
    localparam logic [2:0] LAST_BIT = 3'd5;
`else
    localparam logic [2:0] LAST_BIT = 3'd4;
`endif

    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND     = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_GAP      = 3'd3,
        S_DONE     = 3'd4,
        S_FAIL     = 3'd5
    } state_t;

    state_t     state_r;
    logic [3:0] vote_r;
    logic [2:0] bit_idx_r;
    logic [7:0] tmo_cnt_r;
    logic [3:0] retry_r;

    function automatic logic even_parity(input logic [3:0] v);
        return ^v;
    endfunction

    // Frame layout: index 0 is the start bit, 1..4 carry vote[3] down to vote[0], 5 is parity.
    function automatic logic frame_bit(input logic [3:0] v, input logic [2:0] idx);
        logic b;
        case (idx)
            3'd0:    b = 1'b1;
            3'd1:    b = v[3];
            3'd2:    b = v[2];
            3'd3:    b = v[1];
            3'd4:    b = v[0];
            3'd5:    b = even_parity(v);
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    // Controller FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= S_IDLE;
            vote_r    <= 4'd0;
            bit_idx_r <= 3'd0;
            tmo_cnt_r <= 8'd0;
            retry_r   <= 4'd0;
            tx_req    <= 1'b0;
            tx_data   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r   <= S_SEND;
                        vote_r    <= vote;
                        err       <= 1'b0;
                        retry_r   <= 4'd0;
                        bit_idx_r <= 3'd0;
                        tmo_cnt_r <= 8'd0;
                        tx_req    <= 1'b1;
                        tx_data   <= 1'b1;
                        busy      <= 1'b1;
                    end else begin
                        tx_req  <= 1'b0;
                        tx_data <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                S_SEND: begin
                    tx_req <= 1'b1;
                    busy   <= 1'b1;
                    if (bit_idx_r == LAST_BIT) begin
                        state_r   <= S_WAIT_ACK;
                        tx_data   <= 1'b0;
                        tmo_cnt_r <= 8'd0;
                    end else begin
                        bit_idx_r <= bit_idx_r + 3'd1;
                        tx_data   <= frame_bit(vote_r, bit_idx_r + 3'd1);
                    end
                end
                S_WAIT_ACK: begin
                    busy    <= 1'b1;
                    tx_data <= 1'b0;
                    // An acknowledge arriving on the timeout cycle still counts as success.
                    if (rx_ack) begin
                        state_r <= S_DONE;
                        tx_req  <= 1'b0;
                        done    <= 1'b1;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        tx_req <= 1'b0;
                        if (retry_r < RETRY_MAX) begin
                            retry_r <= retry_r + 4'd1;
                            state_r <= S_GAP;
                        end else begin
                            state_r <= S_FAIL;
                            err     <= 1'b1;
                        end
                    end else begin
                        tx_req    <= 1'b1;
                        tmo_cnt_r <= tmo_cnt_r + 8'd1;
                    end
                end
                S_GAP: begin
                    state_r   <= S_SEND;
                    bit_idx_r <= 3'd0;
                    tmo_cnt_r <= 8'd0;
                    tx_req    <= 1'b1;
                    tx_data   <= 1'b1;
                    busy      <= 1'b1;
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    tx_req  <= 1'b0;
                    tx_data <= 1'b0;
                    busy    <= 1'b0;
                end
                S_FAIL: begin
                    state_r <= S_IDLE;
                    tx_req  <= 1'b0;
                    tx_data <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    tx_req  <= 1'b0;
                    tx_data <= 1'b0;
                    busy    <= 1'b0;
                    err     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_b10_vote_tx.sv
// Scoreboard bench for b10_vote_tx: a transaction-level model queues per-cycle expected outputs,
// an independent monitor pops and compares them on every falling clock edge.
module tb_b10_vote_tx;

    localparam int TIMEOUT   = 4;
    localparam int MAX_RETRY = 1;
`ifdef B10_VOTE_TX_PARITY_EN
    localparam int FL = 6;
`else
    localparam int FL = 5;
`endif

    typedef struct packed {
        logic       start;
        logic [3:0] vote;
        logic       ack;
    } drv_t;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [3:0] vote;
    logic       rx_ack;
    logic       tx_req;
    logic       tx_data;
    logic       busy;
    logic       done;
    logic       err;

    int         vectors = 0;
    int         miscompares = 0;
    logic [4:0] exp_q[$];
    drv_t       drv_q[$];
    logic       err_model;

    b10_vote_tx #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .vote    (vote),
        .rx_ack  (rx_ack),
        .tx_req  (tx_req),
        .tx_data (tx_data),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Outputs packed as {tx_req, tx_data, busy, done, err}.
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({tx_req, tx_data, busy, done, err} !== e) begin
                    miscompares++;
                    $display("FAIL trace @%0t: got {req,data,busy,done,err}=%b expected %b",
                             $time, {tx_req, tx_data, busy, done, err}, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    task automatic add(input logic [4:0] e, input logic s, input logic [3:0] v, input logic a);
        drv_t d;
        d.start = s;
        d.vote  = v;
        d.ack   = a;
        exp_q.push_back(e);
        drv_q.push_back(d);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rv();
        return 4'($urandom_range(0, 15));
    endfunction

    // Transaction model: attempt ack_att is acknowledged on its WAIT_ACK cycle ack_t;
    // ack_att > MAX_RETRY means the receiver never answers.
    task automatic build_txn(input logic [3:0] v, input int ack_att, input int ack_t);
        logic fb[6];
        logic acked;
        logic finished;
        logic a;
        fb[0] = 1'b1;
        fb[1] = v[3];
        fb[2] = v[2];
        fb[3] = v[1];
        fb[4] = v[0];
        fb[5] = ^v;
        acked = 1'b0;
        finished = 1'b0;
        add({4'b0000, err_model}, 1'b1, v, rb());
        for (int att = 0; att <= MAX_RETRY; att++) begin
            if (!finished) begin
                for (int b = 0; b < FL; b++)
                    add({1'b1, fb[b], 3'b100}, rb(), rv(), rb());
                for (int t = 0; t < TIMEOUT; t++) begin
                    if (!finished) begin
                        a = (att == ack_att) && (t == ack_t);
                        add(5'b10100, rb(), rv(), a);
                        if (a) begin
                            acked = 1'b1;
                            finished = 1'b1;
                        end
                    end
                end
                if (!acked) begin
                    if (att < MAX_RETRY) begin
                        add(5'b00100, rb(), rv(), rb());
                    end else begin
                        add(5'b00101, rb(), rv(), rb());
                        finished = 1'b1;
                    end
                end
            end
        end
        if (acked) begin
            add(5'b00110, rb(), rv(), rb());
            add(5'b00000, 1'b0, rv(), rb());
            err_model = 1'b0;
        end else begin
            add(5'b00001, 1'b0, rv(), rb());
            err_model = 1'b1;
        end
    endtask

    task automatic run_txn(input logic [3:0] v, input int ack_att, input int ack_t);
        drv_t d;
        @(posedge clock);
        #1;
        build_txn(v, ack_att, ack_t);
        while (drv_q.size() != 0) begin
            d = drv_q.pop_front();
            start  = d.start;
            vote   = d.vote;
            rx_ack = d.ack;
            if (drv_q.size() != 0) begin
                @(posedge clock);
                #1;
            end
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            @(negedge clock);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected cycles never observed, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] v;
        reset_n = 1'b1;
        start = 1'b0;
        vote = 4'd0;
        rx_ack = 1'b0;
        err_model = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_outputs", {tx_req, tx_data, busy, done, err}, 5'b00000);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // Directed cases: nominal, parity pattern, single retry, exhaustion,
        // ack on the timeout cycle (also clears err), ack on the last retry's final cycle.
        run_txn(4'b1010, 0, 0);
        run_txn(4'b0111, 0, 0);
        run_txn(rv(), 1, 0);
        run_txn(rv(), MAX_RETRY + 1, 0);
        run_txn(rv(), 0, TIMEOUT - 1);
        run_txn(rv(), MAX_RETRY, TIMEOUT - 1);
        run_txn(rv(), MAX_RETRY + 1, 0);

        for (int n = 0; n < 40; n++)
            run_txn(rv(), $urandom_range(0, MAX_RETRY + 1), $urandom_range(0, TIMEOUT - 1));

        // Reset during the third SEND bit must clear everything immediately with no pulse.
        v = rv();
        @(posedge clock);
        #1;
        start = 1'b1;
        vote = v;
        rx_ack = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
            vote = rv();
        end
        chk("third_bit", {tx_req, tx_data, busy, done}, {1'b1, v[2], 2'b10});
        reset_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {tx_req, tx_data, busy, done, err}, 5'b00000);
        start = 1'b0;
        repeat (2) begin
            @(negedge clock);
            chk("held_reset_outputs", {tx_req, tx_data, busy, done, err}, 5'b00000);
        end
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_reset_idle", {tx_req, tx_data, busy, done, err}, 5'b00000);
        err_model = 1'b0;

        run_txn(4'b1010, 0, 0);
        for (int n = 0; n < 5; n++)
            run_txn(rv(), $urandom_range(0, MAX_RETRY + 1), $urandom_range(0, TIMEOUT - 1));

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
